// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
//   DIV_WIDTH    default operand/result width
//   div_op_e     RV64M divide/remainder operation encodings
//   div_state_e  sequencer states
package div_pkg;

    localparam int unsigned DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/sub64.sv
// Trial subtractor for the restoring divider: diff = x - y, ripple borrow.
//   x, y    N-bit minuend / subtrahend
//   diff    N-bit difference (mod 2^N)
//   borrow  set when x < y (unsigned)
module sub64
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic p;
        assign p         = x[i] ^ y[i];
        assign diff[i]   = p ^ bw[i];
        assign bw[i+1]   = (~x[i] & y[i]) | (~p & bw[i]);
    end

    assign borrow = bw[N];

endmodule

// File: rtl/seq_divider64.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU, one quotient bit
// per cycle, MSB first.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       request, accepted only in IDLE or DONE
//   op          operation, sampled with start
//   a, b        dividend / divisor, sampled with start
//   busy        high while iterating (CALC) and sign-fixing (FIX)
//   done        one-cycle pulse; result valid in that cycle
//   result      quotient or remainder, held until the next accepted start
module seq_divider64
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    div_state_e       state, state_nxt;
    div_op_e          op_q;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r;

    logic             accept, special;
    logic [WIDTH-1:0] special_res, fix_res;
    logic             in_signed, in_rem;
    logic [WIDTH:0]   trial_x, trial_y, diff;
    logic             borrow;
    logic             unused_bits;

    assign in_signed = ~op[0];
    assign in_rem    = op[1];

    // Shifted partial remainder keeps its top bit (WIDTH+1 wide) so large
    // unsigned divisors never lose the bit shifted out of rem.
    assign trial_x     = {rem, dvd[WIDTH-1]};
    assign trial_y     = {1'b0, dvs};
    assign unused_bits = diff[WIDTH] ^ trial_x[WIDTH];

    sub64 #(.N(WIDTH + 1)) u_sub (
        .x      (trial_x),
        .y      (trial_y),
        .diff   (diff),
        .borrow (borrow)
    );

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (b == '0) begin
            special     = 1'b1;
            special_res = in_rem ? a : '1;
        end else if (in_signed && (a == INT_MIN) && (b == '1)) begin
            special     = 1'b1;
            special_res = in_rem ? '0 : a;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = special ? S_DONE : S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC:  if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC) || (state == S_FIX);
    assign done = (state == S_DONE);

    always_comb begin
        fix_res = dvd;
        case (op_q)
            OP_DIV:  fix_res = neg_q ? negate(dvd) : dvd;
            OP_DIVU: fix_res = dvd;
            OP_REM:  fix_res = neg_r ? negate(rem) : rem;
            OP_REMU: fix_res = rem;
            default: fix_res = dvd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_DIV;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            op_q  <= div_op_e'(op);
            dvd   <= (in_signed && a[WIDTH-1]) ? negate(a) : a;
            dvs   <= (in_signed && b[WIDTH-1]) ? negate(b) : b;
            neg_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= in_signed & a[WIDTH-1];
            rem   <= '0;
            cnt   <= '0;
        end else if (state == S_CALC) begin
            rem <= borrow ? trial_x[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~borrow};
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 result <= '0;
        else if (accept && special) result <= special_res;
        else if (state == S_FIX)    result <= fix_res;
    end

endmodule

// File: tb/tb_seq_divider64.sv
module tb_seq_divider64;

    localparam int unsigned W = 64;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    seq_divider64 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model of RV64M divide/remainder semantics.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [63:0] sx, sy;
        logic ovf;
        sx  = x;
        sy  = y;
        ovf = (x == MIN64) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
        case (o)
            2'b00:   return (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? x : 64'(sx / sy));
            2'b01:   return (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
            2'b10:   return (y == 0) ? x : (ovf ? 64'd0 : 64'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Drive one request for a single cycle and queue its expected result.
    task automatic start_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
    endtask

    // Cycles counted from the accept edge; capped at 200.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #3;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== '0)  begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        int lat;
        logic [63:0] exp;
        for (int unsigned k = 0; k < 2; k++) begin
            start_op(k == 0 ? 2'b01 : 2'b11, 64'd100, 64'd7);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat !== 66) begin errors++; $display("FAIL unsigned_latency[%0d]: got %0d want 66", k, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL unsigned_result[%0d]: got %h want %h", k, result, exp); end
        end
    endtask

    task automatic test_signed;
        int lat;
        logic [63:0] exp;
        for (int unsigned k = 0; k < 2; k++) begin
            start_op(k == 0 ? 2'b00 : 2'b10, -64'sd100, 64'd7);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat !== 66) begin errors++; $display("FAIL signed_latency[%0d]: got %0d want 66", k, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL signed_result[%0d]: got %h want %h", k, result, exp); end
        end
    endtask

    task automatic test_overflow;
        int lat;
        logic [63:0] exp;
        for (int unsigned k = 0; k < 2; k++) begin
            start_op(k == 0 ? 2'b00 : 2'b10, MIN64, 64'hFFFF_FFFF_FFFF_FFFF);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat !== 1) begin errors++; $display("FAIL overflow_latency[%0d]: got %0d want 1", k, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL overflow_result[%0d]: got %h want %h", k, result, exp); end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        logic [63:0] exp;
        for (int unsigned k = 0; k < 4; k++) begin
            start_op(2'(k), 64'd5, 64'd0);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divzero_busy[%0d]: got %b want 0", k, busy); end
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_latency[%0d]: got %0d want 1", k, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL divzero_result[%0d]: got %h want %h", k, result, exp); end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] exp;
        start_op(2'b01, 64'hDEAD_BEEF_1234_5678, 64'd12345);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL calc_busy: got %b want 1", busy); end
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 64'd999;
        b     = 64'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        exp = sb_q.pop_front();
        checks++; if (lat >= 200) begin errors++; $display("FAIL ignore_timeout: got %0d cycles want done before 200", lat); end
        checks++; if (result !== exp) begin errors++; $display("FAIL ignore_result: got %h want %h", result, exp); end
        // start raised during the DONE cycle
        start = 1'b1;
        op    = 2'b11;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        b     = 64'h8000_0000_0000_0001;
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        wait_done(lat);
        exp = sb_q.pop_front();
        checks++; if (lat !== 66) begin errors++; $display("FAIL b2b_latency: got %0d want 66", lat); end
        checks++; if (result !== exp) begin errors++; $display("FAIL b2b_result: got %h want %h", result, exp); end
    endtask

    task automatic test_random;
        int lat;
        logic [63:0] exp, x, y;
        logic [1:0] o;
        for (int unsigned k = 0; k < 8; k++) begin
            o = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            y = (k % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom} >> $urandom_range(0, 60);
            if (k % 3 == 0) y = -y;
            if (y == 0) y = 64'd3;
            start_op(o, x, y);
            wait_done(lat);
            exp = sb_q.pop_front();
            checks++; if (lat !== 66) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 66", k, lat); end
            checks++; if (result !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", k, o, x, y, result, exp); end
        end
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 64'd1000;
        b     = 64'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (result !== '0)  begin errors++; $display("FAIL abort_result: got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int unsigned c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity %b want 0", seen_done); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
